frame_uart_streamer: RTL and testbench

//  Parametrised successor to the camera frame-to-UART controller. On each rising edge of camera

---
 rtl/frame_uart_streamer.sv | 218 +++++++++++++++++++++
 tb/tb_frame_uart_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_uart_streamer.sv
// rtl/frame_uart_streamer.sv - streams one stored frame from frame RAM to a byte-wide UART TX per VSYNC edge
module frame_uart_streamer #(
    parameter int           BYTES_PER_FRAME = 9216,
    parameter int           ADDR_W          = 15,
    parameter int           CTRL_GAP        = 1085,
    parameter int           BYTE_GAP        = 1085,
    parameter int           CNT_W           = 16,
    parameter bit           HEADER_EN       = 1'b1,
    parameter logic [7:0]   SYNC0           = 8'hAA,
    parameter logic [7:0]   SYNC1           = 8'h55
) (
    input  logic                Clk,
    input  logic                i_Rst,
    input  logic                i_VS,
    input  logic                i_Enable,
    input  logic [3:0]          i_Decimate,
    output logic [ADDR_W-1:0]   o_Rd_Addr,
    input  logic [7:0]          i_Rd_Data,
    output logic [7:0]          o_Tx_Data,
    output logic                o_Tx_Valid,
    input  logic                i_Tx_Ready,
    output logic                o_Frame_Indicator,
    output logic                o_Busy,
    output logic [CNT_W-1:0]    o_Frames_Sent,
    output logic [CNT_W-1:0]    o_Frames_Dropped
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE_GAP,
        S_HDR0,
        S_HGAP0,
        S_HDR1,
        S_HGAP1,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_GAP,
        S_POST_GAP
    } state_t;

    // A gap of N occupies N cycles; a gap of 0 still costs the one cycle spent in the state.
    localparam logic [CNT_W-1:0]  CTRL_LAST = (CTRL_GAP == 0) ? '0 : CNT_W'(CTRL_GAP - 1);
    localparam logic [CNT_W-1:0]  BYTE_LAST = (BYTE_GAP == 0) ? '0 : CNT_W'(BYTE_GAP - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_frames_sent;
    logic [CNT_W-1:0]   r_frames_dropped;
    logic [3:0]         r_dec;
    logic               r_vs_s1;
    logic               r_vs_s2;
    logic               r_vs_s3;

    logic               w_vs_rise;
    logic               w_xfer;
    logic               w_ctrl_done;
    logic               w_byte_done;

    assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
    assign w_xfer      = r_tx_valid & i_Tx_Ready;
    assign w_ctrl_done = (r_gap_cnt == CTRL_LAST);
    assign w_byte_done = (r_gap_cnt == BYTE_LAST);

    always_ff @(posedge Clk) begin
        if (i_Rst) begin
            r_state          <= S_IDLE;
            r_rd_addr        <= '0;
            r_tx_data        <= '0;
            r_tx_valid       <= 1'b0;
            r_gap_cnt        <= '0;
            r_frames_sent    <= '0;
            r_frames_dropped <= '0;
            r_dec            <= '0;
            r_vs_s1          <= 1'b0;
            r_vs_s2          <= 1'b0;
            r_vs_s3          <= 1'b0;
        end else begin
            r_vs_s1 <= i_VS;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;

            // Edges arriving mid-frame are only counted; the running frame carries on.
            if (w_vs_rise && (r_state != S_IDLE) && (r_frames_dropped != '1)) begin
                r_frames_dropped <= r_frames_dropped + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_rd_addr <= '0;
                    r_gap_cnt <= '0;
                    if (w_vs_rise) begin
                        if (i_Enable && (r_dec == 4'd0)) begin
                            r_dec   <= i_Decimate;
                            r_state <= S_PRE_GAP;
                        end else if (r_dec != 4'd0) begin
                            r_dec <= r_dec - 4'd1;
                        end
                    end
                end

                S_PRE_GAP: begin
                    if (w_ctrl_done) begin
                        r_gap_cnt <= '0;
                        if (HEADER_EN) begin
                            r_tx_data  <= SYNC0;
                            r_tx_valid <= 1'b1;
                            r_state    <= S_HDR0;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_HDR0: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_HGAP0;
                    end
                end

                S_HGAP0: begin
                    if (w_byte_done) begin
                        r_gap_cnt  <= '0;
                        r_tx_data  <= SYNC1;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_HDR1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_HDR1: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_HGAP1;
                    end
                end

                S_HGAP1: begin
                    if (w_byte_done) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_FETCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                // Address is already on the RAM port; data appears one cycle later in LATCH.
                S_FETCH: begin
                    r_state <= S_LATCH;
                end

                S_LATCH: begin
                    r_tx_data  <= i_Rd_Data;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end

                S_SEND: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (w_byte_done) begin
                        r_gap_cnt <= '0;
                        if (r_rd_addr < LAST_ADDR) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_rd_addr <= '0;
                            r_state   <= S_POST_GAP;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_POST_GAP: begin
                    if (w_ctrl_done) begin
                        r_gap_cnt <= '0;
                        if (r_frames_sent != '1) begin
                            r_frames_sent <= r_frames_sent + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_gap_cnt  <= '0;
                    r_rd_addr  <= '0;
                end
            endcase
        end
    end

    assign o_Rd_Addr         = r_rd_addr;
    assign o_Tx_Data         = r_tx_data;
    assign o_Tx_Valid        = r_tx_valid;
    assign o_Frame_Indicator = (r_state == S_IDLE);
    assign o_Busy            = (r_state != S_IDLE);
    assign o_Frames_Sent     = r_frames_sent;
    assign o_Frames_Dropped  = r_frames_dropped;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// tb/tb_frame_uart_streamer.sv - scoreboard and vector-table bench for frame_uart_streamer
module tb_frame_uart_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  dec = 4'd0;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        ind;
    logic        busy;
    logic [15:0] sent;
    logic [15:0] dropped;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    bit         stall_en = 1'b0;
    int         stall_left = 0;
    int         stall_seen = 0;
    bit         hold12 = 1'b0;

    typedef struct {
        logic       en;
        logic [3:0] dec;
        logic       start;
        int         exp_sent;
        int         exp_dropped;
    } vec_t;

    vec_t tbl[8];

    frame_uart_streamer #(
        .BYTES_PER_FRAME(4),
        .ADDR_W(4),
        .CTRL_GAP(5),
        .BYTE_GAP(3),
        .CNT_W(16),
        .HEADER_EN(1'b1),
        .SYNC0(8'hAA),
        .SYNC1(8'h55)
    ) dut (
        .Clk(clk),
        .i_Rst(rst),
        .i_VS(vs),
        .i_Enable(en),
        .i_Decimate(dec),
        .o_Rd_Addr(rd_addr),
        .i_Rd_Data(rd_data),
        .o_Tx_Data(tx_data),
        .o_Tx_Valid(tx_valid),
        .i_Tx_Ready(tx_ready),
        .o_Frame_Indicator(ind),
        .o_Busy(busy),
        .o_Frames_Sent(sent),
        .o_Frames_Dropped(dropped)
    );

    always #5 clk = ~clk;

    // Frame RAM model: RAM[a] = 0x10 + a, one cycle read latency
    always @(posedge clk) rd_data <= 8'h10 + {4'h0, rd_addr};

    always @(posedge clk) begin
        #1;
        if (stall_en && tx_valid && tx_data == 8'h11 && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left = stall_left - 1;
        end else if (hold12 && tx_valid && tx_data == 8'h12) begin
            tx_ready = 1'b0;
        end else begin
            tx_ready = 1'b1;
        end
    end

    // Scoreboard: every transfer pops one expected byte
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte actual=%02h required=none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    failures++;
                    $display("FAIL tx_byte actual=%02h required=%02h", tx_data, e);
                end
            end
        end
        if (!rst && stall_en && tx_valid && !tx_ready) begin
            stall_seen++;
            checks++;
            if (tx_data !== 8'h11) begin
                failures++;
                $display("FAIL stall_data actual=%02h required=11", tx_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    endtask

    task automatic pulse_vs();
        @(posedge clk); #1 vs = 1'b1;
        repeat (3) @(posedge clk);
        #1 vs = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_busy(input logic val, input int bound, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === val) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=timeout required=busy_%0b", nm, val);
        end
    endtask

    task automatic watch_idle(input int cycles, input string nm);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=busy required=idle", nm);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'd2, 1'b1, 4, 1};
        tbl[1] = '{1'b1, 4'd2, 1'b0, 4, 1};
        tbl[2] = '{1'b1, 4'd2, 1'b0, 4, 1};
        tbl[3] = '{1'b1, 4'd2, 1'b1, 5, 1};
        tbl[4] = '{1'b1, 4'd2, 1'b0, 5, 1};
        tbl[5] = '{1'b1, 4'd2, 1'b0, 5, 1};
        tbl[6] = '{1'b0, 4'd0, 1'b0, 5, 1};
        tbl[7] = '{1'b1, 4'd0, 1'b1, 6, 1};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_addr", 32'(rd_addr), 32'h0);
        chk("reset_data", 32'(tx_data), 32'h0);
        chk("reset_valid", 32'(tx_valid), 32'h0);
        chk("reset_ind", 32'(ind), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_sent", 32'(sent), 32'h0);
        chk("reset_dropped", 32'(dropped), 32'h0);

        // Single frame, Ready always high
        push_frame();
        pulse_vs();
        wait_busy(1'b1, 20, "t1_start");
        chk("t1_ind_during", 32'(ind), 32'h0);
        wait_busy(1'b0, 500, "t1_end");
        chk("t1_ind_after", 32'(ind), 32'h1);
        chk("t1_sent", 32'(sent), 32'h1);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'h0);

        // Ready stall for 20 cycles on byte 0x11
        stall_en = 1'b1;
        stall_left = 20;
        stall_seen = 0;
        push_frame();
        pulse_vs();
        wait_busy(1'b0, 600, "t2_end");
        stall_en = 1'b0;
        chk("t2_stall_cycles", 32'(stall_seen), 32'd20);
        chk("t2_sent", 32'(sent), 32'h2);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'h0);

        // Second VS mid-frame is dropped
        push_frame();
        pulse_vs();
        wait_busy(1'b1, 20, "t3_start");
        repeat (10) @(posedge clk);
        pulse_vs();
        wait_busy(1'b0, 500, "t3_end");
        watch_idle(60, "t3_no_restart");
        chk("t3_sent", 32'(sent), 32'h3);
        chk("t3_dropped", 32'(dropped), 32'h1);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'h0);

        // Decimation and enable table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            en = tbl[i].en;
            dec = tbl[i].dec;
            if (tbl[i].start) push_frame();
            pulse_vs();
            if (tbl[i].start) begin
                wait_busy(1'b1, 20, $sformatf("vec%0d_start", i));
                wait_busy(1'b0, 500, $sformatf("vec%0d_end", i));
            end else begin
                watch_idle(60, $sformatf("vec%0d_idle", i));
            end
            chk($sformatf("vec%0d_sent", i), 32'(sent), 32'(tbl[i].exp_sent));
            chk($sformatf("vec%0d_dropped", i), 32'(dropped), 32'(tbl[i].exp_dropped));
            chk($sformatf("vec%0d_queue", i), 32'(exp_q.size()), 32'h0);
        end

        // Enable dropped mid-frame: frame still completes
        @(posedge clk); #1 en = 1'b1; dec = 4'd0;
        push_frame();
        pulse_vs();
        wait_busy(1'b1, 20, "t5_start");
        #1 en = 1'b0;
        wait_busy(1'b0, 500, "t5_end");
        chk("t5_sent", 32'(sent), 32'd7);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'h0);
        #1 en = 1'b1;

        // Reset while byte 0x12 is pending
        hold12 = 1'b1;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        pulse_vs();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (tx_valid && tx_data == 8'h12 && !tx_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t6_reach_12", 32'(seen), 32'h1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid", 32'(tx_valid), 32'h0);
        chk("t6_addr", 32'(rd_addr), 32'h0);
        chk("t6_ind", 32'(ind), 32'h1);
        chk("t6_sent", 32'(sent), 32'h0);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'h0);
        rst = 1'b0;
        hold12 = 1'b0;
        push_frame();
        pulse_vs();
        wait_busy(1'b1, 20, "t6_restart");
        wait_busy(1'b0, 500, "t6_end");
        chk("t6_sent_after", 32'(sent), 32'h1);
        chk("t6_queue_after", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
